// File: rtl/floating_point_greater.sv
// Strict greater-than comparator for the 13-bit sign-magnitude float format
// {sign[12], exponent[11:8], fraction[7:0]}, with value (-1)^s * 0.m * 2^e.
// Unnormalized fractions are compared by true value.
// All-zero fractions are zero, whatever the sign and exponent.
// The result is registered with a single cycle of latency.
module floating_point_greater (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [12:0] i_float1,
    input  logic [12:0] i_float2,
    output logic        o_res
);

    // Leading-zero count of the fraction (0..7).
    // A zero fraction returns 0; the caller handles zero operands separately.
    function automatic logic [2:0] count_lz(input logic [7:0] frac);
        logic [2:0] lz;
        lz = 3'd0;
        casez (frac)
            8'b1???????: lz = 3'd0;
            8'b01??????: lz = 3'd1;
            8'b001?????: lz = 3'd2;
            8'b0001????: lz = 3'd3;
            8'b00001???: lz = 3'd4;
            8'b000001??: lz = 3'd5;
            8'b0000001?: lz = 3'd6;
            8'b00000001: lz = 3'd7;
            default:     lz = 3'd0;
        endcase
        return lz;
    endfunction

    // Ordering key for the magnitude: {effective exponent + 7, normalized fraction}.
    // The effective exponent spans -7..15, so the biased value spans 0..22 and fits 5 bits.
    // Any nonzero key has its fraction MSB set and is therefore above zero's key of 0.
    // This lets one unsigned compare order all magnitudes, zero included.
    function automatic logic [12:0] magnitude_key(input logic [12:0] f);
        logic [2:0]  lz;
        logic [4:0]  ee_biased;
        logic [7:0]  nm;
        logic [12:0] key;
        key = 13'd0;
        lz  = count_lz(f[7:0]);
        nm  = f[7:0] << lz;
        ee_biased = {1'b0, f[11:8]} + 5'd7 - {2'b00, lz};
        if (f[7:0] == 8'd0) begin
            key = 13'd0;
        end else begin
            key = {ee_biased, nm};
        end
        return key;
    endfunction

    logic [12:0] key1_s;
    logic [12:0] key2_s;
    logic        neg1_s;
    logic        neg2_s;
    logic        res_s;
    logic        res_r;

    // Derive magnitude keys and effective signs.
    // A zero is treated as non-negative, so +0 and -0 compare equal.
    always_comb begin
        key1_s = magnitude_key(i_float1);
        key2_s = magnitude_key(i_float2);
        neg1_s = i_float1[12] & (i_float1[7:0] != 8'd0);
        neg2_s = i_float2[12] & (i_float2[7:0] != 8'd0);
    end

    // Strict greater-than decision from the effective signs and magnitude keys.
    always_comb begin
        res_s = 1'b0;
        case ({neg1_s, neg2_s})
            2'b00:   res_s = (key1_s > key2_s);
            2'b01:   res_s = 1'b1;
            2'b10:   res_s = 1'b0;
            2'b11:   res_s = (key1_s < key2_s);
            default: res_s = 1'b0;
        endcase
    end

    // Result register.
    // Reset clears it immediately, discarding any in-flight result.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            res_r <= 1'b0;
        end else begin
            res_r <= res_s;
        end
    end

    assign o_res = res_r;

endmodule

// File: tb/tb_floating_point_greater.sv
// Directed self-checking bench for floating_point_greater.
module tb_floating_point_greater;

    logic        i_clk;
    logic        i_rst_n;
    logic [12:0] i_float1;
    logic [12:0] i_float2;
    logic        o_res;

    int errors;
    int checks;

    floating_point_greater floating_point (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_float1 (i_float1),
        .i_float2 (i_float2),
        .o_res    (o_res)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Encodings used below
    localparam logic [12:0] P1_0    = 13'b0_0001_10000000; // +1.0
    localparam logic [12:0] P1_875  = 13'b0_0001_11110000; // +1.875
    localparam logic [12:0] N1_0    = 13'b1_0001_10000000; // -1.0
    localparam logic [12:0] N1_875  = 13'b1_0001_11110000; // -1.875
    localparam logic [12:0] PZERO   = 13'b0_0101_00000000; // +0
    localparam logic [12:0] NZERO   = 13'b1_0000_00000000; // -0
    localparam logic [12:0] N0_5    = 13'b1_0000_10000000; // -0.5
    localparam logic [12:0] U1_0    = 13'b0_0010_01000000; // +1.0 unnormalized
    localparam logic [12:0] U1_0P   = 13'b0_0010_01000001; // slightly above +1.0
    localparam logic [12:0] TINY1   = 13'b0_0000_00000001; // 2^-8
    localparam logic [12:0] TINY2   = 13'b0_0000_00000010; // 2^-7
    localparam logic [12:0] BIG     = 13'b0_1111_10000000; // 2^14
    localparam logic [12:0] BIGM    = 13'b0_1110_11111111; // just below 2^14
    localparam logic [12:0] NTINY1  = 13'b1_0000_00000001; // -2^-8

    // Apply a pair between edges and return just after the next rising edge
    task automatic drive_pair(input logic [12:0] a, input logic [12:0] b);
        @(negedge i_clk);
        i_float1 = a;
        i_float2 = b;
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        i_rst_n  = 1'b0;
        i_float1 = P1_875;
        i_float2 = P1_0;
        #1;
        checks++;
        if (o_res !== 1'b0) begin
            errors++;
            $display("FAIL reset_initial: o_res=%b expected 0", o_res);
        end
        repeat (2) @(posedge i_clk);
        #1;
        checks++;
        if (o_res !== 1'b0) begin
            errors++;
            $display("FAIL reset_held: o_res=%b expected 0", o_res);
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        checks++;
        if (o_res !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_load: o_res=%b expected 1", o_res);
        end
    endtask

    task automatic test_table(input string name, input logic [12:0] a[],
                              input logic [12:0] b[], input logic exp[]);
        for (int i = 0; i < a.size(); i++) begin
            drive_pair(a[i], b[i]);
            checks++;
            if (o_res !== exp[i]) begin
                errors++;
                $display("FAIL %s[%0d]: f1=%b f2=%b o_res=%b expected %b",
                         name, i, a[i], b[i], o_res, exp[i]);
            end
        end
    endtask

    task automatic test_positive();
        test_table("positive", '{P1_0, P1_875, BIG, BIGM, TINY1, TINY2},
                               '{P1_875, P1_0, BIGM, BIG, TINY2, TINY1},
                               '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1});
    endtask

    task automatic test_mixed_sign();
        test_table("mixed_sign", '{P1_0, N1_875, NTINY1, TINY1},
                                 '{N1_875, P1_0, TINY1, NTINY1},
                                 '{1'b1, 1'b0, 1'b0, 1'b1});
    endtask

    task automatic test_negative();
        test_table("negative", '{N1_0, N1_875, N1_0},
                               '{N1_875, N1_0, N1_0},
                               '{1'b1, 1'b0, 1'b0});
    endtask

    task automatic test_zero();
        test_table("zero", '{PZERO, NZERO, PZERO, N0_5, TINY1, NZERO},
                           '{NZERO, PZERO, N0_5, PZERO, NZERO, TINY1},
                           '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
    endtask

    task automatic test_unnormalized();
        test_table("unnormalized", '{U1_0, P1_0, U1_0P, P1_0},
                                   '{P1_0, U1_0, P1_0, U1_0P},
                                   '{1'b0, 1'b0, 1'b1, 1'b0});
    endtask

    task automatic test_back_to_back();
        test_table("back_to_back", '{P1_875, P1_0, P1_875, P1_0, N1_0},
                                   '{P1_0, P1_875, P1_0, P1_875, N1_875},
                                   '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1});
    endtask

    task automatic test_async_reset();
        drive_pair(P1_875, P1_0);
        checks++;
        if (o_res !== 1'b1) begin
            errors++;
            $display("FAIL async_pre: o_res=%b expected 1", o_res);
        end
        #2;
        i_rst_n = 1'b0;
        #1;
        checks++;
        if (o_res !== 1'b0) begin
            errors++;
            $display("FAIL async_drop: o_res=%b expected 0", o_res);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge i_clk);
            #1;
            checks++;
            if (o_res !== 1'b0) begin
                errors++;
                $display("FAIL async_hold[%0d]: o_res=%b expected 0", i, o_res);
            end
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        #1;
        checks++;
        if (o_res !== 1'b0) begin
            errors++;
            $display("FAIL async_release_no_stale: o_res=%b expected 0", o_res);
        end
        @(posedge i_clk);
        #1;
        checks++;
        if (o_res !== 1'b1) begin
            errors++;
            $display("FAIL async_release_load: o_res=%b expected 1", o_res);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_positive();
        test_mixed_sign();
        test_negative();
        test_zero();
        test_unnormalized();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
